// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a circular buffer of instruction words feeding a
// processor IF stage. A two-state issue FSM (IDLE/RUN) pops one word per
// non-stalled cycle. Once the queue runs dry it issues NOP bubbles, and after
// DRAIN_CYCLES consecutive bubbles it drops enable and returns to IDLE.
module instr_fetch_queue #(
    parameter int          DEPTH        = 8,
    parameter int          DRAIN_CYCLES = 5,
    parameter logic [31:0] NOP          = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [31:0]              push_instr,
    input  logic                     stall,
    input  logic                     flush,
    output logic [31:0]              instr_out,
    output logic                     enable,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The pointers carry one extra wrap bit, so full and empty can be told apart.
    logic [AW:0]   rd_q, rd_d;
    logic [AW:0]   wr_q, wr_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   instr_q, instr_d;
    state_t        state_q, state_d;
    logic [BW-1:0] bub_q, bub_d;
    logic          ovf_q, ovf_d;

    logic [AW:0]   count_s;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;

    assign count_s   = wr_q - rd_q;
    assign full_s    = (count_s == (AW+1)'(DEPTH));
    assign empty_s   = (count_s == (AW+1)'(0));
    // Full is judged on the pre-edge count, so a same-cycle pop cannot make room.
    assign push_ok_s = push & ~full_s & ~flush;

    assign instr_out = instr_q;
    assign enable    = (state_q == RUN);
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_s;
    assign overflow  = ovf_q;

    // Next-state logic for the pointers, the issue FSM, the bubble counter and the sticky overflow flag.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = push_ok_s ? (wr_q + (AW+1)'(1)) : wr_q;
        ovf_d   = ovf_q | (push & full_s & ~flush);
        instr_d = instr_q;
        state_d = state_q;
        bub_d   = bub_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    rd_d    = wr_q;
                    instr_d = NOP;
                end else if (!empty_s && !stall) begin
                    instr_d = mem_q[rd_q[AW-1:0]];
                    rd_d    = rd_q + (AW+1)'(1);
                    state_d = RUN;
                    bub_d   = BW'(0);
                end else begin
                    instr_d = NOP;
                end
            end
            RUN: begin
                if (flush || (!stall && empty_s)) begin
                    // A flush counts as a bubble issue, just like running dry.
                    if (flush) begin
                        rd_d = wr_q;
                    end else begin
                        rd_d = rd_q;
                    end
                    instr_d = NOP;
                    if (bub_q == BW'(DRAIN_CYCLES - 1)) begin
                        bub_d   = BW'(0);
                        state_d = IDLE;
                    end else begin
                        bub_d = bub_q + BW'(1);
                    end
                end else if (stall) begin
                    instr_d = instr_q;
                end else begin
                    instr_d = mem_q[rd_q[AW-1:0]];
                    rd_d    = rd_q + (AW+1)'(1);
                    bub_d   = BW'(0);
                end
            end
            default: begin
                state_d = IDLE;
                instr_d = NOP;
                bub_d   = BW'(0);
            end
        endcase
    end

    // State registers, cleared asynchronously so that a reset aborts the run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            instr_q <= NOP;
            state_q <= IDLE;
            bub_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            instr_q <= instr_d;
            state_q <= state_d;
            bub_q   <= bub_d;
            ovf_q   <= ovf_d;
        end
    end

    // Queue storage. The contents need no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q[AW-1:0]] <= push_instr;
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8: queue entries; a power of two, at least 2.
REQ-002 Parameter DRAIN_CYCLES, default 5: number of consecutive bubble issues before the run ends.
REQ-003 Parameter NOP, default 32'h0000_0000: instruction word issued as a bubble.
REQ-004 clk  in  1: single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 push  in  1: write push_instr into the queue this cycle.
REQ-007 push_instr  in  32: instruction word to enqueue.
REQ-008 stall  in  1: the downstream pipeline holds its IF stage, so the queue freezes issue.
REQ-009 flush  in  1: discard all queued instructions (branch redirect).
REQ-010 instr_out  out  32: registered instruction driven into the processor instr_in.
REQ-011 enable  out  1: registered processor enable.
REQ-012 full  out  1: count == DEPTH.
REQ-013 empty  out  1: count == 0.
REQ-014 count  out  log2(DEPTH)+1: number of occupied entries.
REQ-015 overflow  out  1: sticky flag, set when a push is dropped.

Function
REQ-016 Storage: circular buffer with read and write pointers that wrap modulo DEPTH; count is derived from or tracked with the pointers; FIFO order is preserved.
REQ-017 Push is accepted when push=1, full=0 and flush=0; full is evaluated on the pre-edge count, so a push while full is dropped even if a pop occurs in the same cycle.
REQ-018 A dropped push sets overflow to 1; overflow stays 1 until reset.
REQ-019 The issue FSM has two states, IDLE and RUN; enable=1 exactly in RUN.
REQ-020 IDLE behaviour: instr_out=NOP and no pop occurs.
REQ-021 IDLE -> RUN: when empty=0 and stall=0, the head is popped into instr_out and enable rises on the same edge.
REQ-022 RUN issue cycle (stall=0, flush=0), queue non-empty: pop the head into instr_out and clear the bubble counter.
REQ-023 RUN issue cycle, queue empty: instr_out=NOP and the bubble counter increments.
REQ-024 RUN -> IDLE: on the edge where the bubble counter reaches DRAIN_CYCLES, enable falls and the counter clears.
REQ-025 Stall (flush=0): instr_out, state, bubble counter and read pointer all hold; push is still accepted.
REQ-026 Flush: count becomes 0 (read pointer set to write pointer) and instr_out becomes NOP; a RUN-state bubble counter increments as for an empty issue; flush has priority over stall, push and pop; a same-cycle push is discarded without setting overflow.
REQ-027 No bypass: an entry pushed at edge N is issuable no earlier than edge N+1, so an empty-queue push yields instr_out valid 2 edges after the push is sampled.
REQ-028 Issue throughput: one instruction per non-stalled cycle; push throughput: one per cycle.
REQ-029 Simultaneous push and pop on a non-full, non-flush cycle: count is unchanged.

Reset
REQ-030 While rst_n=0, with no clock required: pointers=0, count=0, empty=1, full=0, overflow=0, state=IDLE, enable=0, instr_out=NOP, bubble counter=0.
REQ-031 Deassertion of rst_n is not assumed synchronous; the first valid push is the first rising edge with rst_n=1.
REQ-032 A reset asserted mid-run aborts immediately: queued entries are lost and enable falls asynchronously.

Verification
REQ-033 Push addi 0x20020004, add 0x00421820, sw 0xAC430000, lw 0x8C410000, and 0x00232024 on consecutive cycles, stall=0 -> enable rises one edge after the first push; instr_out shows the five words in order on consecutive edges; then 5 NOP cycles; then enable=0.
REQ-034 Push 9 words with DEPTH=8 and stall=1 -> count=8, full=1, 9th word dropped, overflow=1; release stall -> exactly 8 words issued in order.
REQ-035 Queue holds 3 words in RUN, stall=1 for 4 cycles while 2 more are pushed -> instr_out frozen, count=5; after release -> the 5 words issue in order with no duplicate or skip.
REQ-036 Queue holds 4 words, flush=1 and push=1 in the same cycle -> count=0, instr_out=NOP, overflow=0, pushed word never issued.
REQ-037 Pointer wrap: 20 push/pop pairs at steady state -> count constant, order preserved across wrap.
REQ-038 rst_n=0 asserted between clock edges during RUN with count=3 -> enable=0 and empty=1 before the next edge; after release the queue is IDLE and empty.
